// File: rtl/dcache_req_queue_if.sv
// Request/response bundle between the core, the request queue and the L1 data cache.
// The queue takes the slave view; the core/cache side takes the master view.
interface dcache_req_queue_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int DEPTH_BITS   = 2
);
    logic                      core_read;
    logic                      core_write;
    logic [DATA_WIDTH/8-1:0]   core_w_byte_en;
    logic [ADDRESS_BITS-1:0]   core_address;
    logic [DATA_WIDTH-1:0]     core_data_in;
    logic                      core_req_ready;
    logic [DATA_WIDTH-1:0]     core_data_out;
    logic [ADDRESS_BITS-1:0]   core_out_address;
    logic                      core_valid;
    logic                      core_req_err;

    logic                      read;
    logic                      write;
    logic [DATA_WIDTH/8-1:0]   w_byte_en;
    logic [ADDRESS_BITS-1:0]   address;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      cache_ready;
    logic                      cache_valid;
    logic [DATA_WIDTH-1:0]     cache_data_out;
    logic [ADDRESS_BITS-1:0]   cache_out_address;

    logic [DEPTH_BITS:0]       occupancy;

    modport slave (
        input  core_read, core_write, core_w_byte_en, core_address, core_data_in,
        output core_req_ready, core_data_out, core_out_address, core_valid, core_req_err,
        output read, write, w_byte_en, address, data_in,
        input  cache_ready, cache_valid, cache_data_out, cache_out_address,
        output occupancy
    );

    modport master (
        output core_read, core_write, core_w_byte_en, core_address, core_data_in,
        input  core_req_ready, core_data_out, core_out_address, core_valid, core_req_err,
        input  read, write, w_byte_en, address, data_in,
        output cache_ready, cache_valid, cache_data_out, cache_out_address,
        input  occupancy
    );
endinterface

// File: rtl/dcache_req_queue.sv
// In-order request queue in front of the L1 data cache: buffers core loads/stores
// and issues them one at a time, returning load data to the core.
module dcache_req_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int DEPTH_BITS   = 2
) (
    input logic              clock,
    input logic              reset,
    dcache_req_queue_if.slave bus
);
    localparam int BE_BITS = DATA_WIDTH / 8;
    localparam int DEPTH   = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    typedef struct packed {
        logic                    is_write;
        logic [BE_BITS-1:0]      w_byte_en;
        logic [ADDRESS_BITS-1:0] address;
        logic [DATA_WIDTH-1:0]   data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    entry_t                  entries [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr;
    logic [DEPTH_BITS-1:0]   rd_ptr;
    logic [DEPTH_BITS:0]     count;
    state_t                  state;
    state_t                  next_state;
    logic                    pending_write;
    logic                    req_ready;
    logic                    enq;
    logic                    deq;
    logic                    capture_load;
    entry_t                  head;

    logic                    issue_read;
    logic                    issue_write;
    logic [BE_BITS-1:0]      issue_be;
    logic [ADDRESS_BITS-1:0] issue_address;
    logic [DATA_WIDTH-1:0]   issue_data;

    logic [DATA_WIDTH-1:0]   load_data;
    logic [ADDRESS_BITS-1:0] load_address;
    logic                    load_valid;
    logic                    req_err;

    assign req_ready = (count != FULL_COUNT);
    assign enq       = (bus.core_read ^ bus.core_write) & req_ready;
    assign deq       = (state == ISSUE);
    assign head      = entries[rd_ptr];

    // Storage carries no reset: occupancy and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (enq) begin
            entries[wr_ptr] <= '{is_write:  bus.core_write,
                                 w_byte_en: bus.core_w_byte_en,
                                 address:   bus.core_address,
                                 data:      bus.core_data_in};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pending_write <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ISSUE) pending_write <= head.is_write;
        end
    end

    // Cache-side bus is only non-zero during the single ISSUE cycle.
    always_comb begin
        next_state    = state;
        capture_load  = 1'b0;
        issue_read    = 1'b0;
        issue_write   = 1'b0;
        issue_be      = '0;
        issue_address = '0;
        issue_data    = '0;
        case (state)
            IDLE: begin
                if (count != '0 && bus.cache_ready) next_state = ISSUE;
            end
            ISSUE: begin
                issue_read    = ~head.is_write;
                issue_write   = head.is_write;
                issue_be      = head.w_byte_en;
                issue_address = head.address;
                issue_data    = head.data;
                next_state    = WAIT;
            end
            WAIT: begin
                if (pending_write) begin
                    if (bus.cache_ready) next_state = IDLE;
                end else if (bus.cache_valid) begin
                    capture_load = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_valid   <= 1'b0;
            load_data    <= '0;
            load_address <= '0;
            req_err      <= 1'b0;
        end else begin
            load_valid <= capture_load;
            req_err    <= bus.core_read & bus.core_write;
            if (capture_load) begin
                load_data    <= bus.cache_data_out;
                load_address <= bus.cache_out_address;
            end
        end
    end

    assign bus.core_req_ready   = req_ready;
    assign bus.core_data_out    = load_data;
    assign bus.core_out_address = load_address;
    assign bus.core_valid       = load_valid;
    assign bus.core_req_err     = req_err;
    assign bus.read             = issue_read;
    assign bus.write            = issue_write;
    assign bus.w_byte_en        = issue_be;
    assign bus.address          = issue_address;
    assign bus.data_in          = issue_data;
    assign bus.occupancy        = count;
endmodule

// File: doc/dcache_req_queue.md
DCACHE_REQ_QUEUE -- requirements
Module: dcache_req_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width in bits.
REQ-002 SHALL have parameter ADDRESS_BITS, default 32, meaning the byte address width.
REQ-003 SHALL have parameter DEPTH_BITS, default 2, meaning log2 of the queue depth (DEPTH = 4).
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state SHALL change on its rising edge only.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have core_read / core_write, input, 1 bit each: processor load / store request.
REQ-007 SHALL have core_w_byte_en, input, DATA_WIDTH/8 bits: store byte enables.
REQ-008 SHALL have core_address, input, ADDRESS_BITS: request address.
REQ-009 SHALL have core_data_in, input, DATA_WIDTH: store data.
REQ-010 SHALL have core_req_ready, output, 1 bit: the queue can accept a request this cycle.
REQ-011 SHALL have core_data_out, output, DATA_WIDTH: load result.
REQ-012 SHALL have core_out_address, output, ADDRESS_BITS: load result address.
REQ-013 SHALL have core_valid, output, 1 bit: load result strobe.
REQ-014 SHALL have core_req_err, output, 1 bit: illegal-request strobe.
REQ-015 SHALL have read, write, w_byte_en, address and data_in as outputs toward the L1 data cache, with widths 1, 1, DATA_WIDTH/8, ADDRESS_BITS and DATA_WIDTH.
REQ-016 SHALL have cache_ready (1), cache_valid (1), cache_data_out (DATA_WIDTH) and cache_out_address (ADDRESS_BITS) as inputs from the cache.
REQ-017 SHALL have occupancy, output, DEPTH_BITS+1 bits: the number of queued entries.

Function
REQ-018 SHALL implement a FIFO of DEPTH entries; each entry holds {is_write, w_byte_en, address, data}.
REQ-019 core_req_ready SHALL equal (occupancy != DEPTH), combinationally.
REQ-020 Enqueue SHALL occur when exactly one of core_read or core_write is high and core_req_ready is high.
REQ-021 A request with both core_read and core_write high SHALL NOT be enqueued, and SHALL produce a 1-cycle core_req_err pulse on the next cycle.
REQ-022 A request arriving while the queue is full SHALL be ignored without error; holding the request is the core's responsibility.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Occupancy SHALL increment on enqueue only, decrement on dequeue only, and stay unchanged when both happen in the same cycle.
REQ-025 The controller FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-026 IDLE -> ISSUE SHALL occur when occupancy != 0 and cache_ready == 1.
REQ-027 In ISSUE, for exactly one cycle, the block SHALL drive read or write from the head entry together with its address, data_in and w_byte_en; the head entry SHALL then be dequeued and the state SHALL become WAIT.
REQ-028 WAIT (load) -> IDLE SHALL occur on cache_valid == 1; the block SHALL register cache_data_out and cache_out_address into core_data_out/core_out_address and pulse core_valid for 1 cycle on the following cycle.
REQ-029 WAIT (store) -> IDLE SHALL occur on the first cycle with cache_ready == 1 in WAIT; no core_valid pulse SHALL be generated for stores.
REQ-030 read, write, address, data_in and w_byte_en SHALL be 0 in every state except ISSUE.
REQ-031 At most one cache transaction SHALL be outstanding; the minimum issue-to-issue spacing is 3 cycles.
REQ-032 Requests SHALL be issued in strict FIFO order, so load/store ordering is preserved.
REQ-033 An enqueue into an empty queue SHALL be issuable no earlier than the cycle after the enqueue (no bypass path).
REQ-034 A cache_valid arriving outside WAIT, or during a store's WAIT, SHALL be ignored.

Reset
REQ-035 While reset == 0, regardless of clock: pointers = 0, occupancy = 0, FSM = IDLE, and every output = 0 except core_req_ready = 1.
REQ-036 Reset asserted with a transaction in flight SHALL discard it along with all queued entries; a cache response arriving after reset deassertion SHALL be ignored.

Verification
REQ-037 Single load: enqueue read at 0x100 with cache_ready = 1; cache_valid returns data 0xDEADBEEF two cycles after issue -> read pulses once with address 0x100, and core_valid = 1 with core_data_out = 0xDEADBEEF one cycle after cache_valid.
REQ-038 Fill: 5 back-to-back writes with cache_ready = 0 -> occupancy reaches 4, core_req_ready = 0, the 5th write is not stored; releasing cache_ready issues 4 writes in order.
REQ-039 Simultaneous enqueue/dequeue: queue at occupancy 4; in the ISSUE cycle, which dequeues, a new request is presented -> occupancy drops to 3, the new request is accepted the following cycle, and the pointers wrap correctly.
REQ-040 Illegal request: core_read = core_write = 1 -> core_req_err pulses for 1 cycle and occupancy stays unchanged.
REQ-041 Reset mid-WAIT: reset low for 1 cycle while a load is outstanding -> all outputs return to reset values, and a subsequent cache_valid produces no core_valid.
REQ-042 Ordering: write 0x55 to 0x200, then read 0x200 -> the write is issued before the read, and the read issues only after the write completes.
